// File: rtl/ksa_shuffle.sv
// RC4 key-scheduling shuffle over an external 256-byte S-RAM with a 2-cycle read latency.
// Optional macro KSA_INIT_FILL_EN adds an identity-fill pass (s[i]=i) before the shuffle.
`timescale 1ns/1ps
module ksa_shuffle #(
  parameter int KEY_LEN = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_sig,
  input  logic [23:0] secret_key,
  input  logic [7:0]  q_data,
  output logic        finish,
  output logic        ksa_mem_handler,
  output logic [7:0]  address,
  output logic [7:0]  data,
  output logic        wen,
  output logic [3:0]  state_dbg
);

  // Handshake: start_sig is a level request sampled only in IDLE; finish is a
  // single-cycle completion pulse in DONE, after which the block returns to IDLE.

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    START    = 4'd1,
`ifdef KSA_INIT_FILL_EN
    INIT_WR  = 4'd2,
`endif
    SETUP_I  = 4'd3,
    READ_I   = 4'd4,
    SAMPLE_I = 4'd5,
    ADD_J    = 4'd6,
    SETUP_J  = 4'd7,
    READ_J   = 4'd8,
    SAMPLE_J = 4'd9,
    WRITE_I  = 4'd10,
    WRITE_J  = 4'd11,
    NEXT_I   = 4'd12,
    DONE     = 4'd13
  } state_t;

  localparam logic [1:0] K_LAST = 2'(KEY_LEN - 1);

  state_t     state, state_n;
  logic [7:0] i, i_n;
  logic [7:0] j, j_n;
  logic [7:0] si, si_n;
  logic [7:0] sj, sj_n;
  logic [1:0] kidx, kidx_n;
  logic [7:0] key_byte;

  logic       finish_n;
  logic       handler_n;
  logic [7:0] address_n;
  logic [7:0] data_n;
  logic       wen_n;

  assign state_dbg = state;

  // Key byte chosen by a wrapping counter that tracks i mod KEY_LEN.
  always_comb begin
    key_byte = secret_key[7:0];
    case (kidx)
      2'd0:    key_byte = secret_key[23:16];
      2'd1:    key_byte = secret_key[15:8];
      default: key_byte = secret_key[7:0];
    endcase
  end

  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    si_n    = si;
    sj_n    = sj;
    kidx_n  = kidx;
    case (state)
      IDLE: begin
        if (start_sig) state_n = START;
      end
      START: begin
        i_n    = 8'd0;
        j_n    = 8'd0;
        kidx_n = 2'd0;
`ifdef KSA_INIT_FILL_EN
        state_n = INIT_WR;
`else
        state_n = SETUP_I;
`endif
      end
`ifdef KSA_INIT_FILL_EN
      INIT_WR: begin
        i_n = i + 8'd1;
        if (i == 8'd255) state_n = SETUP_I;
      end
`endif
      SETUP_I: state_n = READ_I;
      READ_I:  state_n = SAMPLE_I;
      SAMPLE_I: begin
        si_n    = q_data;
        state_n = ADD_J;
      end
      ADD_J: begin
        j_n     = j + si + key_byte;
        state_n = SETUP_J;
      end
      SETUP_J: state_n = READ_J;
      READ_J:  state_n = SAMPLE_J;
      SAMPLE_J: begin
        sj_n    = q_data;
        state_n = WRITE_I;
      end
      WRITE_I: state_n = WRITE_J;
      WRITE_J: state_n = NEXT_I;
      NEXT_I: begin
        if (i == 8'd255) begin
          state_n = DONE;
        end else begin
          i_n     = i + 8'd1;
          kidx_n  = (kidx == K_LAST) ? 2'd0 : kidx + 2'd1;
          state_n = SETUP_I;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state and next index values, so the
  // bus shows each state's address/data during the cycle that state is held.
  always_comb begin
    finish_n  = 1'b0;
    address_n = 8'd0;
    data_n    = 8'd0;
    wen_n     = 1'b0;
    handler_n = (state_n != IDLE) && (state_n != DONE);
    case (state_n)
`ifdef KSA_INIT_FILL_EN
      INIT_WR: begin
        address_n = i_n;
        data_n    = i_n;
        wen_n     = 1'b1;
      end
`endif
      SETUP_I, READ_I, SAMPLE_I, ADD_J: address_n = i_n;
      SETUP_J, READ_J, SAMPLE_J:        address_n = j_n;
      WRITE_I: begin
        address_n = i_n;
        data_n    = sj_n;
        wen_n     = 1'b1;
      end
      WRITE_J: begin
        address_n = j_n;
        data_n    = si_n;
        wen_n     = 1'b1;
      end
      NEXT_I:  address_n = i_n;
      DONE:    finish_n  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      i               <= 8'd0;
      j               <= 8'd0;
      si              <= 8'd0;
      sj              <= 8'd0;
      kidx            <= 2'd0;
      finish          <= 1'b0;
      ksa_mem_handler <= 1'b0;
      address         <= 8'd0;
      data            <= 8'd0;
      wen             <= 1'b0;
    end else begin
      state           <= state_n;
      i               <= i_n;
      j               <= j_n;
      si              <= si_n;
      sj              <= sj_n;
      kidx            <= kidx_n;
      finish          <= finish_n;
      ksa_mem_handler <= handler_n;
      address         <= address_n;
      data            <= data_n;
      wen             <= wen_n;
    end
  end

endmodule

// File: tb/tb_ksa_shuffle.sv
// Scoreboard bench for ksa_shuffle: S-RAM model with 2-cycle read latency,
// golden software KSA producing the expected write stream and final S contents.
`timescale 1ns/1ps
module tb_ksa_shuffle;

  localparam int KEY_LEN = 3;
`ifdef KSA_INIT_FILL_EN
  localparam int RUN_LAT     = 2817;
  localparam int INIT_WRITES = 256;
`else
  localparam int RUN_LAT     = 2561;
  localparam int INIT_WRITES = 0;
`endif
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_START = 4'd1;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic        start_sig;
  logic [23:0] secret_key;
  logic [7:0]  q_data;
  logic        finish;
  logic        ksa_mem_handler;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        wen;
  logic [3:0]  state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ksa_shuffle #(.KEY_LEN(KEY_LEN)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_sig       (start_sig),
    .secret_key      (secret_key),
    .q_data          (q_data),
    .finish          (finish),
    .ksa_mem_handler (ksa_mem_handler),
    .address         (address),
    .data            (data),
    .wen             (wen),
    .state_dbg       (state_dbg)
  );

  // ---------------- S-RAM model ----------------
  logic [7:0] ram    [256];
  logic [7:0] init_s [256];
  logic [7:0] gold_s [256];
  logic [7:0] addr_q;
  logic       load_en;

  always @(posedge clk) begin
    addr_q <= address;
    q_data <= ram[addr_q];
    if (load_en) begin
      for (int k = 0; k < 256; k++) ram[k] <= init_s[k];
    end else if (wen) begin
      ram[address] <= data;
    end
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] wr_log[$];
  int total;
  int bad;
  int fin_cnt;
  logic fin_prev;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (reset !== 1'b1) begin
      fin_prev = 1'b0;
    end else begin
      if (wen === 1'b1) begin
        wr_log.push_back({address, data});
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write", address, data);
        end else begin
          e = exp_q.pop_front();
          if (e !== {address, data}) begin
            bad++;
            $display("FAIL write: got addr=%0d data=%0d required addr=%0d data=%0d",
                     address, data, e[15:8], e[7:0]);
          end
        end
      end
      if (finish === 1'b1) begin
        fin_cnt++;
        total++;
        if (fin_prev) begin
          bad++;
          $display("FAIL finish_width: got finish high 2 cycles, required 1");
        end
      end
      fin_prev = finish;
    end
  end

  // ---------------- golden model and driver tasks ----------------
  task automatic model_run(input logic [23:0] key);
    int jj;
    logic [7:0] kb;
    logic [7:0] t;
`ifdef KSA_INIT_FILL_EN
    for (int k = 0; k < 256; k++) begin
      exp_q.push_back({8'(k), 8'(k)});
      gold_s[k] = 8'(k);
    end
`endif
    jj = 0;
    for (int k = 0; k < 256; k++) begin
      case (k % KEY_LEN)
        0:       kb = key[23:16];
        1:       kb = key[15:8];
        default: kb = key[7:0];
      endcase
      jj = (jj + int'(gold_s[k]) + int'(kb)) % 256;
      exp_q.push_back({8'(k), gold_s[jj]});
      exp_q.push_back({8'(jj), gold_s[k]});
      t          = gold_s[k];
      gold_s[k]  = gold_s[jj];
      gold_s[jj] = t;
    end
  endtask

  task automatic preload_ram();
    for (int k = 0; k < 256; k++) begin
`ifdef KSA_INIT_FILL_EN
      init_s[k] = ~8'(k);
`else
      init_s[k] = 8'(k);
`endif
      gold_s[k] = init_s[k];
    end
    @(negedge clk);
    load_en = 1'b1;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clk);
    start_sig = 1'b1;
    @(posedge clk);
    #1 start_sig = 1'b0;
  endtask

  task automatic wait_finish(input int c0, output int c);
    c = c0;
    while (c < 5000) begin
      @(negedge clk);
      if (finish === 1'b1) break;
      c++;
    end
  endtask

  task automatic dump_check(input string name);
    int mism;
    mism = 0;
    for (int k = 0; k < 256; k++) if (ram[k] !== gold_s[k]) mism++;
    check({name, "_sram_mismatch_bytes"}, 32'(mism), 32'd0);
  endtask

  task automatic full_run(input logic [23:0] key, input string name, output int base);
    int c;
    int f0;
    secret_key = key;
    preload_ram();
    model_run(key);
    base = wr_log.size();
    f0 = fin_cnt;
    start_run();
    wait_finish(0, c);
    check({name, "_latency"}, 32'(c), 32'(RUN_LAT));
    @(negedge clk);
    @(negedge clk);
    check({name, "_finish_count"}, 32'(fin_cnt - f0), 32'd1);
    check({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    dump_check(name);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] hand [6];
    int base;
    int c;
    int f0;
    hand = '{16'h0000, 16'h0000, 16'h0101, 16'h0101, 16'h0203, 16'h0302};
    total = 0; bad = 0; fin_cnt = 0; fin_prev = 1'b0;
    load_en = 1'b0; start_sig = 1'b0; secret_key = 24'h0; reset = 1'b1;

    #3 reset = 1'b0;
    #1;
    check("rst_address", 32'(address), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_wen", 32'(wen), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_handler", 32'(ksa_mem_handler), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // Zero key: early iterations are self-swaps, then s[2]/s[3] swap.
    full_run(24'h000000, "key0", base);
    for (int k = 0; k < 6; k++)
      check($sformatf("key0_first_write%0d", k), 32'(wr_log[base + INIT_WRITES + k]), 32'(hand[k]));

    full_run(24'h00033C, "key033c", base);
    full_run(24'hFFFFFF, "keyffffff", base);

    // Reset in the middle of a run aborts it; a fresh start completes.
    secret_key = 24'h123456;
    preload_ram();
    model_run(24'h123456);
    start_run();
    repeat (1000) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_address", 32'(address), 32'd0);
    check("mid_rst_data", 32'(data), 32'd0);
    check("mid_rst_wen", 32'(wen), 32'd0);
    check("mid_rst_handler", 32'(ksa_mem_handler), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_wen_held", 32'(wen), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    full_run(24'h123456, "after_rst", base);

    // start_sig held high: one finish per run, then a new run from IDLE.
    secret_key = 24'h0A0B0C;
    preload_ram();
    model_run(24'h0A0B0C);
    model_run(24'h0A0B0C);
    f0 = fin_cnt;
    @(negedge clk);
    start_sig = 1'b1;
    @(posedge clk);
    wait_finish(0, c);
    check("held_run1_latency", 32'(c), 32'(RUN_LAT));
    @(negedge clk);
    check("held_idle_after_done", 32'(state_dbg), 32'(ST_IDLE));
    check("held_run1_finish_count", 32'(fin_cnt - f0), 32'd1);
    @(negedge clk);
    check("held_restart", 32'(state_dbg), 32'(ST_START));
    start_sig = 1'b0;
    wait_finish(1, c);
    check("held_run2_latency", 32'(c), 32'(RUN_LAT));
    @(negedge clk);
    @(negedge clk);
    check("held_finish_count", 32'(fin_cnt - f0), 32'd2);
    check("held_pending_writes", 32'(exp_q.size()), 32'd0);
    dump_check("held");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
